// File: rtl/frame_readout_pkg.sv
// frame_readout_pkg
// Shared types and constants for the frame readout block.
//   state_t    : readout controller states
//   LANE_B*    : byte-lane indices inside a 32-bit word (little-endian order)
//   ADDR_STEP  : byte distance between consecutive word reads
//   WORD_BYTES : bytes carried by one bus word
//   lane_byte  : picks one byte lane out of a word
package frame_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_UNPACK = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  localparam int ADDR_STEP  = 4;
  localparam int WORD_BYTES = 4;

  // Lane 0 is the lowest-addressed byte, matching the DMA write-side packing.
  function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                           input logic [1:0]  lane);
    logic [7:0] b;
    b = 8'h00;
    case (lane)
      LANE_B0: b = word[7:0];
      LANE_B1: b = word[15:8];
      LANE_B2: b = word[23:16];
      LANE_B3: b = word[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/frame_byte_unpack.sv
// frame_byte_unpack
// Holds one fetched 32-bit word and presents its bytes one at a time on a
// valid/ready stream, lowest lane first.
//   clk, rst_n  : clock, synchronous active-low reset
//   clear       : drop the stream immediately (abort)
//   load        : capture word/count/first/last and present lane 0
//   word        : fetched bus word
//   count       : bytes of this word that belong to the frame (1..4)
//   first       : this word holds frame byte 0 (drives px_sof)
//   last        : this word holds the final frame byte (drives px_eof)
//   px_ready    : downstream ready
//   px_valid, px_data, px_sof, px_eof : registered byte stream
//   fire        : handshake this cycle
//   word_end    : handshake of the final byte of the held word
module frame_byte_unpack
  import frame_readout_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] word,
  input  logic [2:0]  count,
  input  logic        first,
  input  logic        last,
  input  logic        px_ready,
  output logic        px_valid,
  output logic [7:0]  px_data,
  output logic        px_sof,
  output logic        px_eof,
  output logic        fire,
  output logic        word_end
);

  logic [31:0] word_q;
  logic [2:0]  count_q;
  logic        last_q;
  logic [1:0]  lane;
  logic [1:0]  lane_next;
  logic [2:0]  lane_ext_next;

  assign fire          = px_valid && px_ready;
  assign lane_next     = lane + 2'd1;
  assign lane_ext_next = {1'b0, lane} + 3'd1;
  // The held word is finished once the byte just accepted was lane count-1.
  assign word_end      = fire && (lane_ext_next == count_q);

  // Output bytes only move on a handshake, so data/sof/eof hold under
  // backpressure and the word is never re-fetched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q   <= '0;
      count_q  <= '0;
      last_q   <= 1'b0;
      lane     <= LANE_B0;
      px_valid <= 1'b0;
      px_data  <= '0;
      px_sof   <= 1'b0;
      px_eof   <= 1'b0;
    end else if (clear) begin
      px_valid <= 1'b0;
      px_sof   <= 1'b0;
      px_eof   <= 1'b0;
    end else if (load) begin
      word_q   <= word;
      count_q  <= count;
      last_q   <= last;
      lane     <= LANE_B0;
      px_valid <= 1'b1;
      px_data  <= lane_byte(word, LANE_B0);
      px_sof   <= first;
      px_eof   <= last && (count == 3'd1);
    end else if (word_end) begin
      px_valid <= 1'b0;
      px_sof   <= 1'b0;
      px_eof   <= 1'b0;
    end else if (fire) begin
      lane     <= lane_next;
      px_data  <= lane_byte(word_q, lane_next);
      px_sof   <= 1'b0;
      px_eof   <= last_q && ((lane_ext_next + 3'd1) == count_q);
    end
  end

endmodule

// File: rtl/frame_readout_wb.sv
// frame_readout_wb
// Wishbone classic read initiator: fetches a frame word by word from memory
// and replays it as an 8-bit pixel stream with start/end-of-frame markers.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, abort        : one-cycle control pulses
//   base_addr, length   : frame address (low two bits ignored) and size in bytes
//   wb_cyc, wb_stb, wb_we, wb_addr, wb_rdata, wb_ack : Wishbone read master
//   px_valid, px_ready, px_data, px_sof, px_eof      : pixel stream
//   busy, done, err, bytes_read                       : status
module frame_readout_wb
  import frame_readout_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic [31:0]       wb_rdata,
  input  logic              wb_ack,
  output logic              px_valid,
  input  logic              px_ready,
  output logic [7:0]        px_data,
  output logic              px_sof,
  output logic              px_eof,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  bytes_read
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] word_addr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  remaining_after;
  logic [2:0]        word_count;
  logic              first_word;
  logic [WAIT_W-1:0] wait_cnt;
  logic              cyc_q;
  logic              timeout_hit;
  logic              take_ack;
  logic              unpack_clear;
  logic              fire;
  logic              word_end;

  assign wb_cyc  = cyc_q;
  assign wb_stb  = cyc_q;
  assign wb_we   = 1'b0;
  assign wb_addr = word_addr;

  // The final word of a frame may carry fewer than four frame bytes.
  always_comb begin
    word_count = 3'(WORD_BYTES);
    if (remaining < LEN_W'(WORD_BYTES)) begin
      word_count = remaining[2:0];
    end
  end

  assign remaining_after = remaining - {{(LEN_W-3){1'b0}}, word_count};
  assign take_ack        = (state == ST_REQ) && !abort && wb_ack;
  assign unpack_clear    = abort && ((state == ST_REQ) || (state == ST_UNPACK));

  frame_byte_unpack u_unpack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (unpack_clear),
    .load     (take_ack),
    .word     (wb_rdata),
    .count    (word_count),
    .first    (first_word),
    .last     (remaining_after == '0),
    .px_ready (px_ready),
    .px_valid (px_valid),
    .px_data  (px_data),
    .px_sof   (px_sof),
    .px_eof   (px_eof),
    .fire     (fire),
    .word_end (word_end)
  );

  // Next-state logic. Abort beats a same-cycle ack; an ack arriving on the
  // final wait cycle still beats the timeout.
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (length == '0) ? ST_FIN : ST_REQ;
        end
      end
      ST_REQ: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (wb_ack) begin
          state_next = ST_UNPACK;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          state_next  = ST_FIN;
          timeout_hit = 1'b1;
        end
      end
      ST_UNPACK: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (word_end) begin
          state_next = (remaining == '0) ? ST_FIN : ST_REQ;
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register plus registered outputs derived from the next state so
  // that cyc/busy/done change in the same cycle the state does.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      word_addr  <= '0;
      remaining  <= '0;
      first_word <= 1'b0;
      wait_cnt   <= '0;
      cyc_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      bytes_read <= '0;
    end else begin
      state <= state_next;
      cyc_q <= (state_next == ST_REQ);
      busy  <= (state_next == ST_REQ) || (state_next == ST_UNPACK);
      done  <= (state_next == ST_FIN);

      if (state == ST_REQ) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if ((state == ST_IDLE) && start) begin
        word_addr  <= base_addr & ~(ADDR_W'(3));
        remaining  <= length;
        first_word <= 1'b1;
        bytes_read <= '0;
        err        <= 1'b0;
      end

      // Address wraps naturally at 2^ADDR_W.
      if (take_ack) begin
        word_addr  <= word_addr + ADDR_W'(ADDR_STEP);
        remaining  <= remaining_after;
        first_word <= 1'b0;
      end

      if (timeout_hit) begin
        err <= 1'b1;
      end

      if (fire) begin
        bytes_read <= bytes_read + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_frame_readout_wb.sv
// tb_frame_readout_wb
// Self-checking bench: a byte-addressed memory model behind a Wishbone
// responder with random ack delay, a random-ready pixel sink, and a
// reference computed directly from frame base/length.
module tb_frame_readout_wb;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] base_addr;
  logic [15:0] length;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_addr;
  logic [31:0] wb_rdata;
  logic        wb_ack;
  logic        px_valid;
  logic        px_ready;
  logic [7:0]  px_data;
  logic        px_sof;
  logic        px_eof;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] bytes_read;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
  } px_rec_t;

  typedef struct {
    logic [31:0] base;
    int          len;
    int          ready_pct;
    int          max_delay;
    int          exp_reads;
    int          exp_cycles;
  } frame_vec_t;

  px_rec_t     rx_q[$];
  logic [31:0] read_log[$];

  int total = 0;
  int bad   = 0;

  int ready_pct       = 100;
  int byte_limit      = 1 << 30;
  int ack_max_delay   = 0;
  int ack_wait        = 0;
  bit no_ack          = 1'b0;
  int done_seen       = 0;
  int stall_bad       = 0;
  int done_timing_bad = 0;
  int bus_bad         = 0;
  int cyc_cycles      = 0;
  bit stall_pending   = 1'b0;
  bit expect_done     = 1'b0;
  px_rec_t held;

  frame_readout_wb #(
    .ADDR_W  (32),
    .LEN_W   (16),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .length     (length),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_rdata   (wb_rdata),
    .wb_ack     (wb_ack),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_data    (px_data),
    .px_sof     (px_sof),
    .px_eof     (px_eof),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bytes_read (bytes_read)
  );

  always #5 clk = ~clk;

  // Memory contents: a byte depends on the low two address bytes, so frames
  // at 0x2000_00xx read back as their own offsets.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Wishbone responder: acks after a random number of idle cycles.
  initial begin
    wb_ack   = 1'b0;
    wb_rdata = '0;
    forever begin
      @(negedge clk);
      if (wb_ack) begin
        wb_ack = 1'b0;
      end else if (wb_cyc && wb_stb && !no_ack) begin
        if (ack_wait == 0) begin
          wb_ack   = 1'b1;
          wb_rdata = mem_word(wb_addr);
          read_log.push_back(wb_addr);
          ack_wait = (ack_max_delay == 0) ? 0 : int'($urandom_range(ack_max_delay, 0));
        end else begin
          ack_wait--;
        end
      end
    end
  end

  // Pixel sink and protocol monitor.
  initial begin
    px_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_pending) begin
        if (!px_valid || px_data !== held.data || px_sof !== held.sof || px_eof !== held.eof)
          stall_bad++;
      end
      if (expect_done) begin
        if (!done || busy) done_timing_bad++;
        expect_done = 1'b0;
      end
      if (done) done_seen++;
      if (wb_cyc) cyc_cycles++;
      if (wb_stb !== wb_cyc || wb_we !== 1'b0) bus_bad++;
      px_ready = (rx_q.size() < byte_limit) && (int'($urandom_range(99, 0)) < ready_pct);
      stall_pending = px_valid && !px_ready;
      held.data = px_data;
      held.sof  = px_sof;
      held.eof  = px_eof;
      if (px_valid && px_ready) begin
        rx_q.push_back('{px_data, px_sof, px_eof});
        if (px_eof) expect_done = 1'b1;
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] b, input logic [15:0] len, input logic with_abort);
    @(negedge clk);
    base_addr = b;
    length    = len;
    start     = 1'b1;
    abort     = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_flags"},
                 64'({wb_cyc, wb_stb, wb_we, px_valid, px_sof, px_eof, busy, done, err}), 64'd0);
    check_output({tag, "_addr"}, 64'(wb_addr), 64'd0);
    check_output({tag, "_data"}, 64'(px_data), 64'd0);
    check_output({tag, "_bytes"}, 64'(bytes_read), 64'd0);
  endtask

  task automatic run_frame(input logic [31:0] b, input int len, input int rp, input int md,
                           input int exp_reads, input int exp_cycles, input string tag);
    int n;
    int bad_bytes;
    int bad_flags;
    int bad_addr;
    logic [31:0] wbase;
    ready_pct = rp;
    ack_max_delay = md;
    ack_wait = 0;
    byte_limit = 1 << 30;
    rx_q.delete();
    read_log.delete();
    done_seen = 0;
    stall_bad = 0;
    done_timing_bad = 0;
    bus_bad = 0;
    apply_stimulus(b, 16'(len), 1'b0);
    check_output({tag, "_start_busy_cyc"}, 64'({busy, wb_cyc}), 64'd3);
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_done_reached"}, 64'(done), 64'd1);
    if (exp_cycles >= 0) check_output({tag, "_latency"}, 64'(n), 64'(exp_cycles));
    repeat (3) @(negedge clk);

    wbase = b & ~32'd3;
    bad_bytes = 0;
    bad_flags = 0;
    for (int i = 0; i < rx_q.size(); i++) begin
      if (rx_q[i].data !== mem_byte(wbase + 32'(i))) bad_bytes++;
      if (rx_q[i].sof !== (i == 0) || rx_q[i].eof !== (i == len - 1)) bad_flags++;
    end
    bad_addr = 0;
    for (int i = 0; i < read_log.size(); i++) begin
      if (read_log[i] !== wbase + 32'(4 * i)) bad_addr++;
    end
    check_output({tag, "_nbytes"}, 64'(rx_q.size()), 64'(len));
    check_output({tag, "_byte_vals"}, 64'(bad_bytes), 64'd0);
    check_output({tag, "_sof_eof"}, 64'(bad_flags), 64'd0);
    check_output({tag, "_nreads"}, 64'(read_log.size()), 64'(exp_reads));
    check_output({tag, "_read_addrs"}, 64'(bad_addr), 64'd0);
    check_output({tag, "_done_count"}, 64'(done_seen), 64'd1);
    check_output({tag, "_bytes_read"}, 64'(bytes_read), 64'(len));
    check_output({tag, "_err_busy"}, 64'({err, busy}), 64'd0);
    check_output({tag, "_stall_hold"}, 64'(stall_bad), 64'd0);
    check_output({tag, "_eof_done"}, 64'(done_timing_bad), 64'd0);
    check_output({tag, "_bus_ctrl"}, 64'(bus_bad), 64'd0);
  endtask

  initial begin
    frame_vec_t vecs[6];
    int n;
    logic [31:0] rb;
    int rl;

    vecs[0] = '{32'h2000_0000, 64, 100, 0, 16, 80};
    vecs[1] = '{32'h2000_0000, 64, 50, 5, 16, -1};
    vecs[2] = '{32'h2000_0003, 6, 100, 0, 2, 8};
    vecs[3] = '{32'h2000_0000, 1, 100, 0, 1, 2};
    vecs[4] = '{32'hFFFF_FFF8, 12, 80, 2, 3, -1};
    vecs[5] = '{32'h2000_0102, 7, 60, 1, 2, -1};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    base_addr = '0;
    length = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].base, vecs[v].len, vecs[v].ready_pct, vecs[v].max_delay,
                vecs[v].exp_reads, vecs[v].exp_cycles, $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 4; r++) begin
      rb = $urandom;
      rl = int'($urandom_range(40, 1));
      run_frame(rb, rl, int'($urandom_range(100, 30)), int'($urandom_range(4, 0)),
                (rl + 3) / 4, -1, $sformatf("rnd%0d", r));
    end

    // Zero-length frame: done next cycle, no bus activity.
    cyc_cycles = 0;
    apply_stimulus(32'h2000_0000, 16'd0, 1'b0);
    check_output("len0_done_now", 64'({done, busy}), 64'd2);
    @(negedge clk);
    check_output("len0_done_gone", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check_output("len0_no_cyc", 64'(cyc_cycles), 64'd0);

    // Start and abort together while idle: start wins.
    rx_q.delete();
    ready_pct = 100;
    ack_max_delay = 0;
    ack_wait = 0;
    apply_stimulus(32'h2000_0020, 16'd4, 1'b1);
    check_output("start_abort_busy", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("start_abort_done", 64'(done), 64'd1);
    check_output("start_abort_nbytes", 64'(rx_q.size()), 64'd4);
    repeat (2) @(negedge clk);

    // Responder never acks: timeout abort, then a clean frame clears err.
    no_ack = 1'b1;
    apply_stimulus(32'h2000_0000, 16'd8, 1'b0);
    n = 0;
    while (wb_cyc && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check_output("timeout_cyc_cycles", 64'(n), 64'(TO));
    check_output("timeout_done_err", 64'({done, err, busy}), 64'd6);
    check_output("timeout_bytes", 64'(bytes_read), 64'd0);
    @(negedge clk);
    check_output("timeout_err_sticky", 64'({done, err}), 64'd1);
    no_ack = 1'b0;
    run_frame(32'h2000_0000, 20, 100, 1, 5, -1, "after_to");

    // Abort after ten accepted bytes; a start while busy is ignored.
    rx_q.delete();
    read_log.delete();
    done_seen = 0;
    ready_pct = 100;
    ack_max_delay = 0;
    ack_wait = 0;
    byte_limit = 10;
    apply_stimulus(32'h2000_0000, 16'd64, 1'b0);
    n = 0;
    while (rx_q.size() < 10 && n < 500) begin
      @(negedge clk);
      n++;
    end
    apply_stimulus(32'h3000_0000, 16'd4, 1'b0);
    repeat (2) @(negedge clk);
    check_output("busy_start_ignored", 64'({busy, px_valid}), 64'd3);
    check_output("busy_start_addr", 64'(wb_addr), 64'h2000_000C);
    check_output("pre_abort_bytes", 64'(bytes_read), 64'd10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_outputs", 64'({wb_cyc, px_valid, busy, done}), 64'd0);
    check_output("abort_bytes_read", 64'(bytes_read), 64'd10);
    repeat (5) @(negedge clk);
    check_output("abort_no_done", 64'(done_seen), 64'd0);
    check_output("abort_nbytes", 64'(rx_q.size()), 64'd10);
    n = 0;
    for (int i = 0; i < rx_q.size(); i++) begin
      if (rx_q[i].data !== 8'(i)) n++;
    end
    check_output("abort_byte_vals", 64'(n), 64'd0);
    byte_limit = 1 << 30;

    // Synchronous reset in the middle of a bus cycle.
    no_ack = 1'b1;
    apply_stimulus(32'h2000_0040, 16'd8, 1'b0);
    repeat (3) @(negedge clk);
    check_output("mid_bus_cyc", 64'(wb_cyc), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_state("mid_rst");
    rst_n = 1'b1;
    no_ack = 1'b0;
    @(negedge clk);
    run_frame(32'h2000_0010, 9, 70, 3, 3, -1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
